// File: rtl/pe_macc_sequencer.sv
// Operand/control sequencer for the 64-lane MACC PE.
// Streams K (a-vector, b) beats, then drains the PE and returns its result.
module pe_macc_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MACS   = 64,
    parameter int MAC_EN_DLY = 2,
    parameter int RES_LAT    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CNT_W-1:0]               k_len,
    output logic                           busy,
    output logic                           done,
    input  logic [NUM_MACS*DATA_WIDTH-1:0] in_a_packed,
    input  logic [DATA_WIDTH-1:0]          in_b,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_MACS*DATA_WIDTH-1:0] pe_a_packed,
    output logic [DATA_WIDTH-1:0]          pe_b,
    output logic [1:0]                     pe_tsk_ctrl,
    output logic                           pe_mac_en,
    output logic                           pe_rst_mac,
    input  logic [NUM_MACS*DATA_WIDTH-1:0] pe_o_packed,
    output logic [NUM_MACS*DATA_WIDTH-1:0] res_packed,
    output logic                           res_valid,
    input  logic                           res_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]      k_last;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      drain_cnt;
    logic [MAC_EN_DLY-1:0] dly;
    logic                  accept;
    logic                  go;
    logic                  drain_ok;
    logic                  res_hs;

    assign go          = start && (k_len != '0);
    assign accept      = in_valid && in_ready;
    assign res_hs      = res_valid && res_ready;
    assign pe_tsk_ctrl = 2'd0;
    assign pe_mac_en   = dly[MAC_EN_DLY-1];

    // PE output is final RES_LAT cycles after the last in-flight mac_en leaves
    assign drain_ok = (state == S_DRAIN) && (dly == '0)
                   && (drain_cnt == CNT_W'(RES_LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        in_ready   = 1'b0;
        pe_rst_mac = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go) state_nxt = S_CLR;
            end
            S_CLR: begin
                pe_rst_mac = 1'b1;
                state_nxt  = S_STREAM;
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == k_last)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_ok) state_nxt = S_OUT;
            end
            S_OUT: begin
                if (res_hs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_last      <= '0;
            beat_cnt    <= '0;
            drain_cnt   <= '0;
            dly         <= '0;
            pe_a_packed <= '0;
            pe_b        <= '0;
            res_packed  <= '0;
            res_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == S_IDLE && go) begin
                k_last   <= k_len - CNT_W'(1);
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (accept) begin
                pe_a_packed <= in_a_packed;
                pe_b        <= in_b;
            end

            dly[0] <= accept;
            for (int i = 1; i < MAC_EN_DLY; i++) begin
                dly[i] <= dly[i-1];
            end

            // restart the settle count whenever an enable is still in flight
            if (state != S_DRAIN || dly != '0) begin
                drain_cnt <= '0;
            end else begin
                drain_cnt <= drain_cnt + CNT_W'(1);
            end

            if (drain_ok) begin
                res_packed <= pe_o_packed;
                res_valid  <= 1'b1;
            end else if (res_hs) begin
                res_valid <= 1'b0;
            end

            done <= res_hs;
        end
    end

endmodule

// File: tb/tb_pe_macc_sequencer.sv
// Randomized bench for pe_macc_sequencer with a behavioural PE stand-in.
// Expected sums come from the list of beats offered, lane by lane.
module tb_pe_macc_sequencer;

    localparam int DW  = 8;
    localparam int NM  = 64;
    localparam int VW  = DW * NM;
    localparam int CW  = 16;
    localparam int DLY = 2;
    localparam int RL  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k_len;
    logic          busy;
    logic          done;
    logic [VW-1:0] in_a_packed;
    logic [DW-1:0] in_b;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] pe_a_packed;
    logic [DW-1:0] pe_b;
    logic [1:0]    pe_tsk_ctrl;
    logic          pe_mac_en;
    logic          pe_rst_mac;
    logic [VW-1:0] pe_o_packed;
    logic [VW-1:0] res_packed;
    logic          res_valid;
    logic          res_ready;

    always #5 clk = ~clk;

    pe_macc_sequencer #(
        .DATA_WIDTH(DW), .NUM_MACS(NM), .MAC_EN_DLY(DLY),
        .RES_LAT(RL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .in_a_packed(in_a_packed), .in_b(in_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .pe_a_packed(pe_a_packed), .pe_b(pe_b),
        .pe_tsk_ctrl(pe_tsk_ctrl), .pe_mac_en(pe_mac_en),
        .pe_rst_mac(pe_rst_mac), .pe_o_packed(pe_o_packed),
        .res_packed(res_packed), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    // PE stand-in: input register, 8-bit wrapping accumulators, output register
    logic [VW-1:0] pe_a_r;
    logic [DW-1:0] pe_b_r;
    logic [VW-1:0] pe_acc;

    always @(posedge clk) begin
        if (rst) begin
            pe_a_r      <= '0;
            pe_b_r      <= '0;
            pe_acc      <= '0;
            pe_o_packed <= '0;
        end else begin
            pe_a_r <= pe_a_packed;
            pe_b_r <= pe_b;
            for (int j = 0; j < NM; j++) begin
                if (pe_rst_mac)
                    pe_acc[j*DW +: DW] <= '0;
                else if (pe_mac_en)
                    pe_acc[j*DW +: DW] <= pe_acc[j*DW +: DW]
                                        + DW'(pe_a_r[j*DW +: DW] * pe_b_r);
            end
            pe_o_packed <= pe_acc;
        end
    end

    // event log: cycle numbers at which each observed condition held
    int cyc = 0;
    int acc_q[$];
    int mac_q[$];
    int rstm_q[$];
    int busy_q[$];
    int rv_q[$];
    int done_q[$];

    always @(negedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (pe_mac_en)            mac_q.push_back(cyc);
        if (pe_rst_mac)           rstm_q.push_back(cyc);
        if (busy)                 busy_q.push_back(cyc);
        if (res_valid)            rv_q.push_back(cyc);
        if (done)                 done_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [VW-1:0] a_q[$];
    logic [DW-1:0] b_q[$];

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int n_after(input int q[$], input int t0);
        int n = 0;
        foreach (q[i]) if (q[i] >= t0) n++;
        return n;
    endfunction

    function automatic int first_after(input int q[$], input int t0);
        foreach (q[i]) if (q[i] >= t0) return q[i];
        return -1;
    endfunction

    function automatic logic [VW-1:0] ref_sum();
        logic [VW-1:0] r;
        logic [DW-1:0] s;
        r = '0;
        for (int j = 0; j < NM; j++) begin
            s = '0;
            foreach (a_q[i]) s = s + DW'(a_q[i][j*DW +: DW] * b_q[i]);
            r[j*DW +: DW] = s;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic gen_beat(input int mode, input int i,
                            output logic [VW-1:0] av, output logic [DW-1:0] bv);
        av = '0;
        bv = '0;
        case (mode)
            1: begin
                for (int j = 0; j < NM; j++) av[j*DW +: DW] = DW'(1);
                bv = DW'(i + 1);
            end
            2: begin
                for (int j = 0; j < NM; j++) av[j*DW +: DW] = DW'(j);
                bv = DW'(2);
            end
            3: begin
                for (int j = 0; j < NM; j++) av[j*DW +: DW] = DW'(1);
                bv = DW'(5);
            end
            default: begin
                av = rand_vec();
                bv = DW'($urandom);
            end
        endcase
    endtask

    task automatic feed(input logic [VW-1:0] av, input logic [DW-1:0] bv,
                        input int gap, output bit ok);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_a_packed = av;
        in_b        = bv;
        in_valid    = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        ok = in_ready;
        if (!ok) chk("accept_timeout", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic run_pass(input int k, input int mode, input int bmode,
                            input int bp, input bit stray,
                            output logic [VW-1:0] res);
        int t0, t, gap, mis;
        bit ok;
        int pat[3];
        int aq[$];
        int mq[$];
        logic [VW-1:0] av;
        logic [DW-1:0] bv;
        pat = '{0, 2, 1};
        res = '0;
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < k; i++) begin
            gen_beat(mode, i, av, bv);
            a_q.push_back(av);
            b_q.push_back(bv);
        end
        t0 = cyc;
        start = 1'b1;
        k_len = CW'(k);
        @(posedge clk);
        #1;
        start = 1'b0;
        k_len = CW'($urandom);
        for (int i = 0; i < k; i++) begin
            if (bmode == 1)      gap = pat[i % 3];
            else if (bmode == 2) gap = int'($urandom_range(0, 2));
            else                 gap = 0;
            feed(a_q[i], b_q[i], gap, ok);
            if (!ok) begin
                in_valid = 1'b0;
                return;
            end
        end
        // stray beats after the pass must not be consumed
        in_valid    = 1'b1;
        in_a_packed = rand_vec();
        in_b        = DW'($urandom);
        t = 0;
        @(negedge clk);
        while (!res_valid && t < 100) begin
            t++;
            @(negedge clk);
        end
        #1;
        chk("res_valid_seen", VW'(res_valid), VW'(1));
        if (!res_valid) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        res = res_packed;
        chk("result", res_packed, ref_sum());
        for (int c = 0; c < bp; c++) begin
            @(posedge clk);
            #1;
            start = stray && (c == 1);
            k_len = CW'(3);
            @(negedge clk);
            #1;
            chk("bp_hold_res", res_packed, res);
            chk("bp_hold_ctl", VW'({res_valid, busy, in_ready}), VW'(3'b110));
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        #1;
        chk("done_pulse", VW'({done, res_valid, busy}), VW'(3'b100));
        chk("done_cnt", VW'(n_after(done_q, t0)), VW'(1));
        chk("rst_mac_cnt", VW'(n_after(rstm_q, t0)), VW'(1));
        foreach (acc_q[i]) if (acc_q[i] >= t0) aq.push_back(acc_q[i]);
        foreach (mac_q[i]) if (mac_q[i] >= t0) mq.push_back(mac_q[i]);
        chk("accept_cnt", VW'(aq.size()), VW'(k));
        chk("mac_en_cnt", VW'(mq.size()), VW'(k));
        mis = 0;
        for (int i = 0; i < aq.size() && i < mq.size(); i++)
            if (mq[i] != aq[i] + DLY) mis++;
        chk("mac_en_align", VW'(mis), VW'(0));
        if (mq.size() > 0)
            chk("clr_before_mac",
                VW'(first_after(rstm_q, t0) < mq[0]), VW'(1));
        if (bmode == 0)
            chk("latency",
                VW'(first_after(rv_q, t0) - first_after(busy_q, t0)),
                VW'(k + 1 + DLY + RL));
        @(posedge clk);
        #1;
    endtask

    logic [VW-1:0] r;
    logic [VW-1:0] tens;
    logic [VW-1:0] bv_any;
    int            t0;
    bit            ok;

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        k_len       = '0;
        in_a_packed = '0;
        in_b        = '0;
        in_valid    = 1'b0;
        res_ready   = 1'b0;
        for (int j = 0; j < NM; j++) tens[j*DW +: DW] = DW'(10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_ctl", VW'({busy, in_ready, done, res_valid,
                              pe_mac_en, pe_rst_mac, pe_tsk_ctrl}), VW'(0));
        chk("reset_pe_a", pe_a_packed, '0);
        chk("reset_res", VW'({res_packed, pe_b} != '0), VW'(0));
        @(posedge clk);
        #1;

        run_pass(4, 1, 0, 0, 1'b0, r);
        chk("basic_all_10", r, tens);

        run_pass(3, 2, 1, 0, 1'b0, r);
        chk("bubble_lane5", VW'(r[5*DW +: DW]), VW'(30));
        chk("bubble_lane7", VW'(r[7*DW +: DW]), VW'(42));

        run_pass(5, 0, 0, 5, 1'b1, r);
        run_pass(6, 0, 0, 0, 1'b0, r);

        t0       = cyc;
        start    = 1'b1;
        k_len    = '0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("zero_busy", VW'(n_after(busy_q, t0)), VW'(0));
        chk("zero_rst_mac", VW'(n_after(rstm_q, t0)), VW'(0));
        chk("zero_res_valid", VW'(n_after(rv_q, t0)), VW'(0));
        chk("zero_done", VW'(n_after(done_q, t0)), VW'(0));
        chk("zero_accept", VW'(n_after(acc_q, t0)), VW'(0));

        t0    = cyc;
        start = 1'b1;
        k_len = CW'(8);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bv_any = rand_vec();
            feed(bv_any, DW'($urandom), 0, ok);
        end
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_ctl", VW'({busy, in_ready, done, res_valid,
                               pe_mac_en, pe_rst_mac}), VW'(0));
        chk("midrst_pe_a", pe_a_packed, '0);
        chk("midrst_res", res_packed, '0);
        chk("midrst_done_none", VW'(n_after(done_q, t0)), VW'(0));
        @(posedge clk);
        #1;
        run_pass(2, 3, 0, 0, 1'b0, r);
        chk("after_rst_all_10", r, tens);

        for (int n = 0; n < 4; n++)
            run_pass(int'($urandom_range(1, 9)), 0, 2,
                     int'($urandom_range(0, 3)), 1'b0, r);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
